// File: rtl/board_pkg.sv
// Board-wide types and default timing constants for the 12 MHz system clock.
// The debounce FSM encoding lives here so checkers and monitors can decode the state output.
package board_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } debounce_state_t;

    localparam int unsigned CLK_HZ                    = 12_000_000;
    // 10 ms debounce window and 1 s long-press threshold at CLK_HZ.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = CLK_HZ / 100;
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = CLK_HZ;

endpackage : board_pkg

// File: rtl/synchronizer.sv
// Parameterized N-flop synchronizer for asynchronous pad inputs.
// All stages reset to 0 synchronously.
module synchronizer #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : synchronizer

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes the pad, debounces both edges and emits
// press/release/long-press pulses plus a debounced level. Exposes FSM state for debug.
module button_debouncer
    import board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ena_i,
    input  logic            button_raw_i,
    output logic            pressed_o,
    output logic            press_o,
    output logic            release_o,
    output logic            long_press_o,
    output debounce_state_t state_o
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES == 0) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);
    localparam bit          LONG_EN = (LONG_PRESS_CYCLES != 0);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((LONG_PRESS_CYCLES == 0) ? 0 : LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

    logic button_pad_q;
    logic s;

    debounce_state_t   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              press_d, release_d, long_d;
    logic              pressed_q, press_q, release_q, long_q;

    // Pad capture flop ahead of the synchronizer: s follows button_raw_i three edges later.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            button_pad_q <= 1'b0;
        end else begin
            button_pad_q <= button_raw_i;
        end
    end

    synchronizer #(
        .STAGES (2),
        .WIDTH  (1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (button_pad_q),
        .q_o   (s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        fired_d   = fired_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                    fired_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (LONG_EN && !fired_q && (hold_q == HOLD_LAST)) begin
                    long_d  = 1'b1;
                    fired_d = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to 1 resumes PRESSED with hold/fired untouched.
                if (s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            fired_q   <= 1'b0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            fired_q   <= fired_d;
            pressed_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            press_q   <= press_d & ena_i;
            release_q <= release_d & ena_i;
            long_q    <= long_d & ena_i;
        end
    end

    assign pressed_o    = pressed_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign state_o      = state_q;

endmodule : button_debouncer
